block_mem_scheduler: RTL
========================

// Module: block_mem_scheduler
// PURPOSE
// Sequences and shares the brick block memory (CLEAR/LOAD/PULL/DROP) between
// its requesters. Ball collision logic pushes brick hits into a small clear
// queue, game control requests stage loads and pulls, and an internal timer
// schedules periodic drops. The scheduler issues one memory command at a time,
// tracks the memory's ready/busy handshake and reports completions.
// PARAMETERS
// QDEPTH       4        clear-queue entries (power of 2, 2..16)
// DROP_PERIOD  24'd6000000  clocks between automatic DROP requests while drop_en=1
// PORTS
// clock        in   1   system clock
// reset        in   1   synchronous, active-high reset
// clear_valid  in   1   brick hit offered: push {clear_row,clear_col}
// clear_row    in   5   row 0..29
// clear_col    in   5   col 0..9
// clear_ready  out  1   queue not full; push accepted when clear_valid&&clear_ready
// load_req     in   1   1-cycle pulse: load stage load_stage
// load_stage   in   2   stage number, sampled with load_req
// pull_req     in   1   1-cycle pulse: shift all rows up one (PULL)
// drop_en      in   1   enables drop timer; 0 holds timer at 0
// mem_ready    in   1   block memory idle
// mem_enable   out  1   1-cycle command strobe to block memory
// mem_func     out  2   00 CLEAR, 01 LOAD, 10 PULL, 11 DROP
// mem_row      out  5   CLEAR row (held until next grant)
// mem_col      out  5   CLEAR col (held until next grant)
// mem_stage    out  2   LOAD stage (held until next grant)
// busy         out  1   state != IDLE
// op_done      out  1   1-cycle pulse when a granted command completes
// op_func      out  2   func of completed command, valid with op_done
// BEHAVIOUR
// - All outputs registered. Reset: all outputs 0 except clear_ready=1; queue
//   empty, pending flags 0, timer 0, state IDLE. Reset mid-command aborts
//   silently (no op_done); block memory shares the same reset.
// - Pending: load_pend (+stage latch; later load_req overwrites stage),
//   pull_pend, drop_pend are sticky single flags; repeats while pending merge.
// - Drop timer: counts while drop_en; at DROP_PERIOD-1 wraps to 0, sets drop_pend.
// - FSM: IDLE -> GRANT -> (HOLD | WLOW -> WHIGH) -> IDLE.
//   IDLE: if mem_ready and any request, select by priority
//     LOAD > CLEAR(queue non-empty) > PULL > DROP; go GRANT.
//   GRANT: mem_enable=1 exactly this cycle with func/row/col/stage valid;
//     selected pend flag cleared / queue popped on entry to GRANT.
//   HOLD (CLEAR only): 1 cycle, row/col stable; then op_done, IDLE.
//   WLOW: wait mem_ready=0 (max 1 cycle expected); WHIGH: wait mem_ready=1,
//     then op_done with op_func, IDLE. Minimum CLEAR-to-CLEAR spacing 3 clocks.
// - LOAD grant flushes the clear queue and zeroes the drop timer; a push in
//   the same cycle as the flush is dropped. Push and pop same cycle: count
//   unchanged, FIFO order preserved. Push when full ignored.
// - Requests arriving while busy are queued/pended, never lost (except flush).
// - mem_ready=0 in IDLE (external busy): no grant until it returns to 1.
// TESTING
// 1 reset; push (3,4),(7,9) -> two CLEAR grants in order, mem_row/col 3/4 then
//   7/9, each mem_enable 1 cycle, op_done op_func=00 after HOLD.
// 2 fill queue (4 pushes) -> clear_ready=0; 5th push ignored; pops restore 1.
// 3 load_req stage=2 with 3 queued clears and pull pending -> LOAD first,
//   mem_stage=2, queue flushed, then PULL; op_done 01 only after mem_ready rises.
// 4 DROP_PERIOD=10, drop_en=1 -> DROP grant every ~10 clocks; drop_en=0 stops.
// 5 pull_req twice while LOAD busy -> exactly one PULL issued afterwards.
// 6 reset asserted in WHIGH -> next cycle IDLE, outputs 0, no op_done.

Source files
------------

// File: rtl/block_mem_scheduler_if.sv
// Request, command and completion bundle shared by the requesters,
// the block memory scheduler and the brick block memory.
interface block_mem_scheduler_if;
    logic       clear_valid;
    logic [4:0] clear_row;
    logic [4:0] clear_col;
    logic       clear_ready;
    logic       load_req;
    logic [1:0] load_stage;
    logic       pull_req;
    logic       drop_en;
    logic       mem_ready;
    logic       mem_enable;
    logic [1:0] mem_func;
    logic [4:0] mem_row;
    logic [4:0] mem_col;
    logic [1:0] mem_stage;
    logic       busy;
    logic       op_done;
    logic [1:0] op_func;

    modport slave (
        input  clear_valid, clear_row, clear_col,
        input  load_req, load_stage, pull_req, drop_en,
        input  mem_ready,
        output clear_ready, mem_enable, mem_func,
        output mem_row, mem_col, mem_stage,
        output busy, op_done, op_func
    );

    modport master (
        output clear_valid, clear_row, clear_col,
        output load_req, load_stage, pull_req, drop_en,
        output mem_ready,
        input  clear_ready, mem_enable, mem_func,
        input  mem_row, mem_col, mem_stage,
        input  busy, op_done, op_func
    );
endinterface

// File: rtl/block_mem_scheduler.sv
// Shares the brick block memory between clear queue, load/pull requests
// and the periodic drop timer; one command in flight at a time.
module block_mem_scheduler #(
    parameter int          QDEPTH      = 4,
    parameter logic [23:0] DROP_PERIOD = 24'd6000000
) (
    input  logic                 clock,
    input  logic                 reset,
    block_mem_scheduler_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
    localparam logic [1:0] F_CLEAR = 2'b00;
    localparam logic [1:0] F_LOAD  = 2'b01;
    localparam logic [1:0] F_PULL  = 2'b10;
    localparam logic [1:0] F_DROP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_HOLD, S_WLOW, S_WHIGH
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [9:0]    r_q [QDEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nxt;

    logic          r_load_pend;
    logic          r_pull_pend;
    logic          r_drop_pend;
    logic [1:0]    r_load_stage;
    logic [23:0]   r_timer;

    logic          r_clear_ready;
    logic          r_mem_enable;
    logic [1:0]    r_mem_func;
    logic [4:0]    r_mem_row;
    logic [4:0]    r_mem_col;
    logic [1:0]    r_mem_stage;
    logic          r_busy;
    logic          r_op_done;
    logic [1:0]    r_op_func;

    logic          w_grant;
    logic [1:0]    w_gfunc;
    logic          w_done;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_drop_tick;
    logic [9:0]    w_head;

    assign w_push  = bus.clear_valid && r_clear_ready;
    assign w_pop   = w_grant && (w_gfunc == F_CLEAR);
    assign w_flush = w_grant && (w_gfunc == F_LOAD);
    assign w_head  = r_q[r_rp];
    assign w_drop_tick = bus.drop_en && !w_flush &&
                         (r_timer == DROP_PERIOD - 24'd1);

    // Arbitration and next-state selection
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gfunc     = F_CLEAR;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.mem_ready) begin
                    if (r_load_pend) begin
                        w_grant = 1'b1;
                        w_gfunc = F_LOAD;
                    end else if (r_cnt != '0) begin
                        w_grant = 1'b1;
                        w_gfunc = F_CLEAR;
                    end else if (r_pull_pend) begin
                        w_grant = 1'b1;
                        w_gfunc = F_PULL;
                    end else if (r_drop_pend) begin
                        w_grant = 1'b1;
                        w_gfunc = F_DROP;
                    end
                end
                if (w_grant) w_state_nxt = S_GRANT;
            end
            S_GRANT: begin
                if (r_mem_func == F_CLEAR) w_state_nxt = S_HOLD;
                else                       w_state_nxt = S_WLOW;
            end
            S_HOLD: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_WLOW: begin
                if (!bus.mem_ready) w_state_nxt = S_WHIGH;
            end
            S_WHIGH: begin
                if (bus.mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Clear-queue occupancy after push, pop and flush
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_flush)
            w_cnt_nxt = '0;
        else if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + 1'b1;
        else if (!w_push && w_pop)
            w_cnt_nxt = r_cnt - 1'b1;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Clear-queue storage; pushes coinciding with a flush are dropped
    always_ff @(posedge clock) begin
        if (w_push && !w_flush) r_q[r_wp] <= {bus.clear_row, bus.clear_col};
    end

    // Clear-queue pointers and count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + 1'b1;
                if (w_pop)  r_rp <= r_rp + 1'b1;
            end
        end
    end

    // Sticky request flags, load stage latch and drop timer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_pend  <= 1'b0;
            r_pull_pend  <= 1'b0;
            r_drop_pend  <= 1'b0;
            r_load_stage <= 2'd0;
            r_timer      <= 24'd0;
        end else begin
            r_load_pend <= (r_load_pend && !w_flush) || bus.load_req;
            r_pull_pend <= (r_pull_pend &&
                            !(w_grant && w_gfunc == F_PULL)) || bus.pull_req;
            r_drop_pend <= (r_drop_pend &&
                            !(w_grant && w_gfunc == F_DROP)) || w_drop_tick;
            if (bus.load_req) r_load_stage <= bus.load_stage;
            if (!bus.drop_en || w_flush || w_drop_tick)
                r_timer <= 24'd0;
            else
                r_timer <= r_timer + 24'd1;
        end
    end

    // Registered command, status and completion outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clear_ready <= 1'b1;
            r_mem_enable  <= 1'b0;
            r_mem_func    <= 2'd0;
            r_mem_row     <= 5'd0;
            r_mem_col     <= 5'd0;
            r_mem_stage   <= 2'd0;
            r_busy        <= 1'b0;
            r_op_done     <= 1'b0;
            r_op_func     <= 2'd0;
        end else begin
            r_clear_ready <= (w_cnt_nxt != FULL);
            r_mem_enable  <= w_grant;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_op_done     <= w_done;
            if (w_done) r_op_func <= r_mem_func;
            if (w_grant) begin
                r_mem_func <= w_gfunc;
                if (w_gfunc == F_CLEAR) begin
                    r_mem_row <= w_head[9:5];
                    r_mem_col <= w_head[4:0];
                end
                if (w_gfunc == F_LOAD) r_mem_stage <= r_load_stage;
            end
        end
    end

    assign bus.clear_ready = r_clear_ready;
    assign bus.mem_enable  = r_mem_enable;
    assign bus.mem_func    = r_mem_func;
    assign bus.mem_row     = r_mem_row;
    assign bus.mem_col     = r_mem_col;
    assign bus.mem_stage   = r_mem_stage;
    assign bus.busy        = r_busy;
    assign bus.op_done     = r_op_done;
    assign bus.op_func     = r_op_func;
endmodule
